// File: rtl/writeback_queue.sv
// Writeback queue: buffers results headed for the register file, pops them in
// FIFO order through a registered output stage, and exposes a bypass query.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [4:0]               InRegister,
  input  logic [WIDTH-1:0]         InData,
  input  logic                     DrainEn,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [WIDTH-1:0]         WriteData,
  input  logic [4:0]               QueryRegister,
  output logic                     QueryPending,
  output logic [WIDTH-1:0]         QueryData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       entryReg  [DEPTH];
  logic [WIDTH-1:0] entryData [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic accept;
  logic store;
  logic pop;

  // Handshake: a transfer happens at a rising edge where InValid && InReady;
  // InReady depends only on occupancy and Reset, never on DrainEn or InValid.
  assign Full    = (Count == CW'(DEPTH));
  assign Empty   = (Count == '0);
  assign InReady = !Full && !Reset;
  assign accept  = InValid && InReady;
  assign store   = accept && (InRegister != 5'd0);
  assign pop     = DrainEn && !Empty;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head          <= '0;
      tail          <= '0;
      Count         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      if (store) begin
        entryReg[tail]  <= InRegister;
        entryData[tail] <= InData;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        WriteRegister <= entryReg[head];
        WriteData     <= entryData[head];
        head          <= head + 1'b1;
      end
      RegWrite <= pop;
      Count    <= Count + CW'(store) - CW'(pop);
    end
  end

  logic             hit;
  logic [WIDTH-1:0] hitData;
  logic [PW-1:0]    idx;

  // Scan oldest to youngest so the last match (nearest the tail) wins;
  // the output stage is older than every queued entry.
  always_comb begin
    hit     = RegWrite && (WriteRegister == QueryRegister);
    hitData = WriteData;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < Count) && (entryReg[idx] == QueryRegister)) begin
        hit     = 1'b1;
        hitData = entryData[idx];
      end
    end
    QueryPending = hit && (QueryRegister != 5'd0) && !Reset;
    QueryData    = QueryPending ? hitData : '0;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic, checked
// each cycle against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             Clk;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [4:0]       InRegister;
  logic [WIDTH-1:0] InData;
  logic             DrainEn;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       QueryRegister;
  logic             QueryPending;
  logic [WIDTH-1:0] QueryData;
  logic [2:0]       Count;
  logic             Full;
  logic             Empty;

  writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .DrainEn(DrainEn),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .QueryRegister(QueryRegister), .QueryPending(QueryPending),
    .QueryData(QueryData), .Count(Count), .Full(Full), .Empty(Empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending writes as {register, data}, oldest at the front.
  logic [36:0] expQ[$];
  logic        mRegWrite;
  logic [4:0]  mWrReg;
  logic [31:0] mWrData;
  logic [31:0] rf [32];
  int          peakCount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    logic        mp;
    logic [31:0] md;
    mp = 1'b0;
    md = '0;
    if (!Reset && QueryRegister != 5'd0) begin
      if (mRegWrite && mWrReg == QueryRegister) begin
        mp = 1'b1;
        md = mWrData;
      end
      foreach (expQ[i]) begin
        if (expQ[i][36:32] == QueryRegister) begin
          mp = 1'b1;
          md = expQ[i][31:0];
        end
      end
    end
    chk("count", Count, expQ.size());
    chk("full", Full, expQ.size() == DEPTH);
    chk("empty", Empty, expQ.size() == 0);
    chk("inReady", InReady, (expQ.size() < DEPTH) && !Reset);
    chk("regWrite", RegWrite, mRegWrite);
    chk("writeRegister", WriteRegister, mWrReg);
    chk("writeData", WriteData, mWrData);
    chk("queryPending", QueryPending, mp);
    chk("queryData", QueryData, md);
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then step the model.
  task automatic cycle(input logic rst, input logic v, input logic [4:0] r,
                       input logic [31:0] d, input logic drn, input logic [4:0] q);
    logic        acc;
    logic        pop;
    logic [36:0] e;
    logic        wasRw;
    logic [4:0]  wasReg;
    logic [31:0] wasData;
    Reset = rst; InValid = v; InRegister = r; InData = d; DrainEn = drn; QueryRegister = q;
    #1;
    checkOutputs();
    if (int'(Count) > peakCount) peakCount = int'(Count);
    wasRw = RegWrite; wasReg = WriteRegister; wasData = WriteData;
    @(posedge Clk);
    if (wasRw) rf[wasReg] = wasData;
    if (rst) begin
      expQ.delete();
      mRegWrite = 1'b0;
      mWrReg    = '0;
      mWrData   = '0;
    end else begin
      acc = v && (expQ.size() < DEPTH);
      pop = drn && (expQ.size() > 0);
      if (pop) begin
        e         = expQ.pop_front();
        mRegWrite = 1'b1;
        mWrReg    = e[36:32];
        mWrData   = e[31:0];
      end else begin
        mRegWrite = 1'b0;
      end
      if (acc && r != 5'd0) expQ.push_back({r, d});
    end
    @(negedge Clk);
  endtask

  task automatic idle(input logic drn, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'h0, drn, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    peakCount = 0;
    Reset = 1'b1; InValid = 1'b0; InRegister = '0; InData = '0;
    DrainEn = 1'b1; QueryRegister = '0;
    @(posedge Clk);
    @(negedge Clk);
    mRegWrite = 1'b0; mWrReg = '0; mWrData = '0;

    // Reset state, with stray InValid/DrainEn ignored during reset.
    cycle(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
    idle(1'b0, 1);

    // Single write to r15 with DrainEn high throughout.
    cycle(1'b0, 1'b1, 5'd15, 32'h1B, 1'b1, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    #1;
    chk("r15_regWrite", RegWrite, 1'b1);
    chk("r15_writeRegister", WriteRegister, 5'd15);
    chk("r15_writeData", WriteData, 32'h1B);
    idle(1'b0, 1);
    chk("r15_regfile", rf[15], 32'h1B);

    // Fill to Full, refuse a 5th, then drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 5'(i), 32'hA0 + 32'(i), 1'b0, 5'd0);
    #1;
    chk("fill_full", Full, 1'b1);
    chk("fill_inReady", InReady, 1'b0);
    cycle(1'b0, 1'b1, 5'd5, 32'hA5, 1'b0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
      chk("drain_order", WriteRegister, 5'(i));
    end
    idle(1'b0, 1);
    chk("drain_empty", Empty, 1'b1);

    // Bypass: youngest match wins, r0 and non-matching queries miss.
    cycle(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd7);
    cycle(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd7);
    QueryRegister = 5'd7;
    #1;
    chk("query7_pending", QueryPending, 1'b1);
    chk("query7_data", QueryData, 32'h22);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);

    // Writes to r0 are consumed and never stored.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    idle(1'b1, 2);
    chk("r0_count", Count, 3'd0);
    chk("r0_regWrite", RegWrite, 1'b0);

    // Mid-stream reset drops two queued writes.
    cycle(1'b0, 1'b1, 5'd10, 32'hB1, 1'b0, 5'd0);
    cycle(1'b0, 1'b1, 5'd11, 32'hB2, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    idle(1'b1, 3);
    chk("rst_rf10", rf[10], 32'h0);
    chk("rst_rf11", rf[11], 32'h0);

    // Full with pop: refused that edge, accepted the next.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 5'(i + 20), 32'hC0 + 32'(i), 1'b0, 5'd0);
    cycle(1'b0, 1'b1, 5'd25, 32'hC5, 1'b1, 5'd25);
    cycle(1'b0, 1'b1, 5'd26, 32'hC6, 1'b1, 5'd26);
    #1;
    chk("reuse_count", Count, 3'd3);
    chk("reuse_query", QueryData, 32'hC6);
    idle(1'b1, 5);

    // Back-to-back accepts with continuous drain.
    peakCount = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 5'(i + 1), $urandom, 1'b1, 5'(i));
    idle(1'b1, 3);
    chk("b2b_peak", peakCount, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 15)));
    end
    idle(1'b1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queued register writes; power of two, at least 2.
REQ-002 Parameter: WIDTH, 32, data width in bits.
REQ-003 Port: Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: Reset  input  1  reset; synchronous and active-high.
REQ-005 Port: InValid  input  1  upstream presents a result.
REQ-006 Port: InReady  output  1  queue can accept a result this cycle.
REQ-007 Port: InRegister  input  5  destination register address.
REQ-008 Port: InData  input  WIDTH  result data.
REQ-009 Port: DrainEn  input  1  permits a pop toward the register file this cycle.
REQ-010 Port: RegWrite  output  1  write enable to the register file; registered.
REQ-011 Port: WriteRegister  output  5  write address to the register file; registered.
REQ-012 Port: WriteData  output  WIDTH  write data to the register file; registered.
REQ-013 Port: QueryRegister  input  5  address being read by the decode stage.
REQ-014 Port: QueryPending  output  1  a newer value for QueryRegister is in flight.
REQ-015 Port: QueryData  output  WIDTH  bypass data for QueryRegister.
REQ-016 Port: Count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-017 Port: Full, Empty  output  1 each  Count==DEPTH and Count==0 respectively.

Function
REQ-018 Accept: a result is accepted at an edge when InValid and InReady are both 1.
REQ-019 Ready: InReady is combinational and equals !Full && !Reset; it has no dependence on DrainEn.
REQ-020 Register 0: an accepted result with InRegister==0 is consumed but not stored, so Count does not change.
REQ-021 Storage: a circular buffer with head and tail pointers that wrap modulo DEPTH; ordering is strict FIFO.
REQ-022 Pop: at an edge where DrainEn==1 and Count (pre-edge) > 0, the head entry is loaded into WriteRegister and WriteData, RegWrite is set to 1, and head advances.
REQ-023 Idle: at any other edge RegWrite is set to 0, and WriteRegister and WriteData hold their values.
REQ-024 Latency: a result accepted at edge N is popped no earlier than edge N+1 and is committed by the register file at edge N+2; there is no same-edge pass-through from an empty queue.
REQ-025 Simultaneous events: an accept and a pop at the same edge leave Count unchanged; both pointers advance.
REQ-026 Full: when Full, no accept occurs even if a pop happens at that edge; the slot is reusable from the next cycle.
REQ-027 Empty: DrainEn has no effect while Empty; RegWrite is 0 on the following cycle.
REQ-028 Count arithmetic: Count = Count + accept_stored - pop; it never exceeds DEPTH and never underflows.
REQ-029 Query: QueryPending is combinational; it is 1 iff QueryRegister!=0 and QueryRegister matches either an occupied queue entry or the output stage while RegWrite==1.
REQ-030 Query data: QueryData comes from the youngest match, where the queue tail side is youngest and the output stage is oldest; it is 0 when QueryPending==0.
REQ-031 Query scope: a result being accepted in the current cycle is not visible to the query until after the edge.

Reset
REQ-032 When Reset==1 at an edge: head=tail=0, Count=0, RegWrite=0, WriteRegister=0 and WriteData=0; all queued entries are discarded.
REQ-033 During a reset cycle, InValid and DrainEn are ignored, and InReady and QueryPending are 0.
REQ-034 Reset asserted mid-stream drops all pending writes; after release, the first accepted result is the first one written.

Verification
REQ-035 Reset, then at one edge InValid=1, InRegister=5'b01111, InData=32'h1B, with DrainEn=1: RegWrite=1, WriteRegister=01111 and WriteData=32'h1B during the cycle after the next edge; the register file reads 32'h1B from 01111 afterwards.
REQ-036 With DrainEn=0, accept 4 results to registers 1..4 with data 32'hA1..32'hA4: Full=1, InReady=0 and the 5th offer is refused; then with DrainEn=1, writes appear in order 1..4 on consecutive cycles and Empty=1 afterward.
REQ-037 With DrainEn=0, queue writes of 32'h11 then 32'h22 to register 7 and set QueryRegister=7: QueryPending=1 and QueryData=32'h22; with QueryRegister=0 or 9, QueryPending=0 and QueryData=0.
REQ-038 Accept InRegister=0 with InData=32'hFFFF_FFFF: Count stays 0 and RegWrite never asserts.
REQ-039 With the queue at Count=2, assert Reset for one edge: Count=0 and RegWrite=0, and neither entry is ever written; with the queue at Count=4 and DrainEn=1, the pop at one edge is followed by an accept at the next edge, which is accepted.
REQ-040 With DrainEn=1 and 10 back-to-back accepts: pointers wrap, Count never exceeds 1, and data order is preserved.
